snes_multi_reader: RTL
======================

Name: snes_multi_reader

Overview:
- Parametrised serial gamepad reader and successor to the single-pad SNES reader.
- Drives one shared latch/clock pair to NUM_PADS controllers, each with its own data line, and shifts in NUM_BITS per pad (16 = SNES, 8 = NES).
- All sampling is done in the system clock domain; no derived-clock flops.
- Adds single-shot or continuous polling, an optional active-low inversion, a frame-valid strobe, and per-button press-edge pulses for the processor-side register block.

Parameters:
NUM_PADS, 2, number of controllers sharing latch/clock
NUM_BITS, 16, bits shifted per pad per frame (>=2)
LATCH_CYC, 1200, latch high duration in clk_100M cycles (12 us)
HALF_CYC, 600, each serial-clock high or low phase in cycles (6 us)
IDLE_CYC, 1200, clock-high guard time after the last bit before the frame completes (12 us)
INVERT, 1, 1: line low = pressed, and the register holds 1 = pressed; 0: raw line level

Ports:
clk_100M  input  1  system clock
reset  input  1  synchronous, active-high
poll_en  input  1  1: frames repeat back-to-back
poll_req  input  1  one-cycle pulse: start one frame from IDLE
snes_data  input  NUM_PADS  serial data, one per pad, asynchronous
snes_latch  output  1  shared latch
snes_clk  output  1  shared serial clock
busy  output  1  frame in progress
btn_state  output  NUM_PADS*NUM_BITS  bit [p*NUM_BITS+k] = pad p, k-th bit shifted (k=0 first)
btn_valid  output  1  one-cycle pulse when btn_state updates
btn_press  output  NUM_PADS*NUM_BITS  one-cycle pulse per button that went released->pressed this frame

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; all counters 0.
  - snes_latch=0, snes_clk=1, busy=0.
  - btn_state=0, btn_valid=0, btn_press=0.
  - Synchronizers and the shift register are cleared.
  - Reset asserted mid-frame aborts the frame, drives the reset outputs on the next edge, and leaves btn_state unchanged by the partial frame.
- Input synchronization: snes_data passes through a 2-flop synchronizer per pad. Sampling uses only the synchronized value.
- State machine: IDLE, LATCH, CLK_HI, CLK_LO, GUARD. A single timer is reloaded with (duration-1) on state entry, and the state exits on the cycle the timer reads 0.
- IDLE:
  - Outputs: latch=0, clk=1, busy=0.
  - Transition: goes to LATCH on the next edge if poll_req=1 or poll_en=1.
- LATCH:
  - Outputs: latch=1, clk=1, busy=1, bit index=0.
  - Duration: LATCH_CYC cycles, then CLK_HI.
- CLK_HI:
  - Outputs: latch=0, clk=1.
  - Duration: HALF_CYC cycles.
  - Sampling: on its last cycle, each pad's synchronized bit is shifted into the shift register at position index, then the state goes to CLK_LO.
- CLK_LO:
  - Outputs: clk=0.
  - Duration: HALF_CYC cycles.
  - Transition: if index<NUM_BITS-1, index++ and go to CLK_HI; else go to GUARD.
- GUARD:
  - Outputs: clk=1, latch=0.
  - Duration: IDLE_CYC cycles.
  - Completion: on its last cycle, btn_state <= shift register (XOR INVERT) and btn_valid=1 on the next cycle.
  - btn_press = new & ~old, asserted in the same cycle as btn_valid.
  - Transition: goes to LATCH if poll_en=1, else IDLE.
- Frame length is LATCH_CYC + 2*HALF_CYC*NUM_BITS + IDLE_CYC cycles. With defaults that is 21600 cycles (216 us).
- poll_req while busy is ignored; it is not queued.
- poll_en deasserted mid-frame: the current frame completes, then the block returns to IDLE.
- btn_valid and btn_press are zero on every cycle except the update cycle.
- A disconnected pad (line pulled high) reads all 0 when INVERT=1.
- Timer width is clog2(max(LATCH_CYC,HALF_CYC,IDLE_CYC)). Index width is clog2(NUM_BITS). No wrap-around is permitted.

Test Plan:
1. Test parameters LATCH_CYC=8, HALF_CYC=4, IDLE_CYC=4, NUM_BITS=16, NUM_PADS=2. Stimulus: reset 3 cycles, then a poll_req pulse.
   - Latch is high for exactly 8 cycles starting 1 cycle after poll_req.
   - Exactly 16 clk low pulses of 4 cycles each.
   - busy stays high for 140 cycles, then btn_valid pulses once.
2. Pad0 model drives pattern 0xFFFE (only bit0 low) and pad1 drives 0x7FFF (only bit15 low), INVERT=1.
   - After btn_valid: btn_state[15:0]=0x0001 and btn_state[31:16]=0x8000.
   - btn_press equals btn_state on the first frame.
3. poll_en=1 with the pattern held for 3 frames.
   - btn_valid pulses every 140 cycles.
   - btn_press=0 on frames 2–3.
   - Changing pad0 to 0xFFFC gives btn_press[1]=1 only.
4. Assert reset at cycle 50 of a frame.
   - Next cycle: latch=0, clk=1, busy=0, btn_state=0.
   - No btn_valid occurs.
   - After release the block stays in IDLE until poll_req.
5. poll_req pulsed while busy=1, and poll_en dropped mid-frame.
   - The frame completes normally.
   - No extra frame starts; the block stays in IDLE.
6. NUM_BITS=8, INVERT=0, all data lines high.
   - 8 clock pulses per frame.
   - btn_state=0xFFFF (both pads 0xFF).

Source files
------------

// File: rtl/snes_multi_reader.sv
// Multi-pad serial gamepad reader: one shared latch/clock pair, one data line per pad.
// Frames are timed by a single down-counter; all sampling stays in the clk_100M domain.
module snes_multi_reader #(
  parameter int NUM_PADS  = 2,
  parameter int NUM_BITS  = 16,
  parameter int LATCH_CYC = 1200,
  parameter int HALF_CYC  = 600,
  parameter int IDLE_CYC  = 1200,
  parameter int INVERT    = 1
) (
  input  logic                         clk_100M,
  input  logic                         reset,
  input  logic                         poll_en,
  input  logic                         poll_req,
  input  logic [NUM_PADS-1:0]          snes_data,
  output logic                         snes_latch,
  output logic                         snes_clk,
  output logic                         busy,
  output logic [NUM_PADS*NUM_BITS-1:0] btn_state,
  output logic                         btn_valid,
  output logic [NUM_PADS*NUM_BITS-1:0] btn_press
);

  localparam int W       = NUM_PADS * NUM_BITS;
  localparam int MAX_LH  = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int MAX_CYC = (MAX_LH > IDLE_CYC) ? MAX_LH : IDLE_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_BITS);

  localparam logic [TW-1:0] LATCH_LD = TW'(LATCH_CYC - 1);
  localparam logic [TW-1:0] HALF_LD  = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] IDLE_LD  = TW'(IDLE_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    GUARD
  } state_t;

  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [IW-1:0]         index_reg, index_next;
  logic                  sample_en;
  logic                  frame_done;
  logic                  timer_zero;

  logic [NUM_PADS-1:0]   sync1_reg, sync2_reg;
  logic [W-1:0]          shift_reg, shift_next;
  logic [NUM_BITS-1:0]   bit_mask;
  logic [W-1:0]          btn_new;

  logic                  latch_reg, clk_reg, busy_reg;
  logic [W-1:0]          state_out_reg, press_reg;
  logic                  valid_reg;

  assign timer_zero = (timer_reg == '0);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_zero ? timer_reg : timer_reg - 1'b1;
    index_next = index_reg;
    sample_en  = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = LATCH_LD;
        index_next = '0;
        if (poll_req || poll_en) state_next = LATCH;
      end
      LATCH: begin
        index_next = '0;
        if (timer_zero) begin
          state_next = CLK_HI;
          timer_next = HALF_LD;
        end
      end
      CLK_HI: begin
        if (timer_zero) begin
          sample_en  = 1'b1;
          state_next = CLK_LO;
          timer_next = HALF_LD;
        end
      end
      CLK_LO: begin
        if (timer_zero) begin
          if (index_reg == LAST_IDX) begin
            state_next = GUARD;
            timer_next = IDLE_LD;
          end else begin
            index_next = index_reg + 1'b1;
            state_next = CLK_HI;
            timer_next = HALF_LD;
          end
        end
      end
      GUARD: begin
        if (timer_zero) begin
          frame_done = 1'b1;
          timer_next = LATCH_LD;
          state_next = poll_en ? LATCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Each pad overwrites only the bit at the current index of its own slice.
  assign bit_mask = NUM_BITS'(1) << index_reg;

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    assign shift_next[gi*NUM_BITS +: NUM_BITS] = sample_en
      ? ((shift_reg[gi*NUM_BITS +: NUM_BITS] & ~bit_mask) | (sync2_reg[gi] ? bit_mask : '0))
      : shift_reg[gi*NUM_BITS +: NUM_BITS];
  end

  assign btn_new = (INVERT != 0) ? ~shift_reg : shift_reg;

  always_ff @(posedge clk_100M) begin
    if (reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      index_reg     <= '0;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      shift_reg     <= '0;
      latch_reg     <= 1'b0;
      clk_reg       <= 1'b1;
      busy_reg      <= 1'b0;
      state_out_reg <= '0;
      press_reg     <= '0;
      valid_reg     <= 1'b0;
    end else begin
      sync1_reg <= snes_data;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      timer_reg <= timer_next;
      index_reg <= index_next;
      shift_reg <= shift_next;
      // Pad-facing outputs come straight from flops so the cable sees no decode glitches.
      latch_reg <= (state_next == LATCH);
      clk_reg   <= (state_next != CLK_LO);
      busy_reg  <= (state_next != IDLE);
      valid_reg <= frame_done;
      press_reg <= frame_done ? (btn_new & ~state_out_reg) : '0;
      if (frame_done) state_out_reg <= btn_new;
    end
  end

  assign snes_latch = latch_reg;
  assign snes_clk   = clk_reg;
  assign busy       = busy_reg;
  assign btn_state  = state_out_reg;
  assign btn_valid  = valid_reg;
  assign btn_press  = press_reg;

endmodule
